// File: rtl/ahb_ram_tty_slave.sv
// AHB-Lite slave: word-organised RAM plus a multi-channel console FIFO,
// with programmable wait states and a two-cycle ERROR response.
module ahb_ram_tty_slave #(
  parameter int          RAM_LOG2     = 18,
  parameter int          WAIT_STATES  = 0,
  parameter logic [31:0] TTY_BASE     = 32'h40000000,
  parameter int          TTY_CHANNELS = 4,
  parameter int          FIFO_DEPTH   = 8,
  parameter string       INIT_FILE    = ""
) (
  input  logic        sim_clock,
  input  logic        power_on_reset_n,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic        tty_valid,
  output logic [2:0]  tty_chan,
  output logic [7:0]  tty_data,
  input  logic        tty_ready,
  output logic        stop_req
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  localparam int         PW      = $clog2(FIFO_DEPTH);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [31:0] mem [2**RAM_LOG2];

  state_t               state_q, state_d;
  logic [3:0]           wcnt_q, wcnt_d;
  logic [RAM_LOG2-1:0]  idx_q;
  logic [1:0]           lo_q, size_q;
  logic                 write_q, tty_q, stop_q;
  logic [2:0]           chan_q;

  logic [10:0]          fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [PW:0]          count_q, count_d;

  // Address-phase decode
  logic [31:0] tty_off;
  logic        ram_hit, tty_hit, size_ok, legal, accept;
  logic        unused_ok;

  assign tty_off   = HADDR - TTY_BASE;
  assign ram_hit   = (HADDR[31:RAM_LOG2+2] == '0);
  assign tty_hit   = (tty_off[1:0] == 2'b00) && (tty_off[31:2] < 30'(TTY_CHANNELS));
  assign size_ok   = (HSIZE == 3'd0) || ((HSIZE == 3'd1) && !HADDR[0]) ||
                     ((HSIZE == 3'd2) && (HADDR[1:0] == 2'b00));
  assign legal     = (ram_hit || tty_hit) && size_ok;
  assign accept    = HSEL && HTRANS[1] && HREADY;
  assign unused_ok = HTRANS[0];

  logic full, pop, push, tty_wr, is_cr, stall, done, accept_pt, ram_we;

  assign full     = (count_q == (PW+1)'(FIFO_DEPTH));
  assign tty_valid = (count_q != '0);
  assign pop      = tty_valid && tty_ready;
  assign tty_wr   = tty_q && write_q;
  assign is_cr    = (HWDATA[7:0] == 8'h0D);
  // A carriage return never enters the FIFO, so it never needs to wait for space
  assign stall    = (state_q == S_DATA) && tty_wr && !is_cr && full && !pop;
  assign push     = done && tty_wr && !is_cr;
  assign ram_we   = done && !tty_q && write_q;

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    accept_pt = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: accept_pt = 1'b1;
      S_WAIT: begin
        HREADYOUT = 1'b0;
        if (wcnt_q == 4'd0) state_d = S_DATA;
        else                wcnt_d  = wcnt_q - 4'd1;
      end
      S_DATA: begin
        if (stall) HREADYOUT = 1'b0;
        else begin
          done      = 1'b1;
          accept_pt = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_d   = S_ERR2;
      end
      S_ERR2: begin
        HRESP     = 1'b1;
        accept_pt = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (accept_pt && accept) begin
      state_d = !legal ? S_ERR1 : ((WAIT_STATES > 0) ? S_WAIT : S_DATA);
      wcnt_d  = WS_LOAD;
    end
  end

  always_ff @(posedge sim_clock or negedge power_on_reset_n) begin
    if (!power_on_reset_n) begin
      state_q <= S_IDLE;
      wcnt_q  <= 4'd0;
      idx_q   <= '0;
      lo_q    <= 2'b00;
      size_q  <= 2'b00;
      write_q <= 1'b0;
      tty_q   <= 1'b0;
      chan_q  <= 3'd0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      stop_q  <= done && tty_wr && is_cr;
      if (accept_pt && accept) begin
        idx_q   <= HADDR[RAM_LOG2+1:2];
        lo_q    <= HADDR[1:0];
        size_q  <= HSIZE[1:0];
        write_q <= HWRITE;
        tty_q   <= tty_hit;
        chan_q  <= tty_off[4:2];
      end
    end
  end

  assign stop_req = stop_q;

  logic [3:0] be;
  always_comb begin
    be = 4'b1111;
    case (size_q)
      2'd0:    be = 4'b0001 << lo_q;
      2'd1:    be = lo_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  always_ff @(posedge sim_clock) begin
    if (ram_we)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge sim_clock or negedge power_on_reset_n) begin
    if (!power_on_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge sim_clock) begin
    if (push) fifo_mem[wr_ptr_q] <= {chan_q, HWDATA[7:0]};
  end

  assign tty_chan = tty_valid ? fifo_mem[rd_ptr_q][10:8] : 3'd0;
  assign tty_data = tty_valid ? fifo_mem[rd_ptr_q][7:0]  : 8'd0;

  logic [6:0] cnt7;
  assign cnt7 = 7'(count_q);

  always_comb begin
    HRDATA = 32'd0;
    if (state_q == S_DATA && !write_q)
      HRDATA = tty_q ? {24'd0, full, cnt7} : mem[idx_q];
  end

endmodule
